// File: rtl/sha1_stream_core.sv
// sha1_stream_core: streaming SHA-1 block engine, UNROLL rounds per clock.
// Ports: clk, rst_n, start, msg_valid/msg_ready/msg_data/msg_last, busy, done, digest.
module sha1_stream_core #(
   parameter logic [31:0] H_INIT0 = 32'h67DE2A01,
   parameter logic [31:0] H_INIT1 = 32'hBB03E28C,
   parameter logic [31:0] H_INIT2 = 32'h011EF1DC,
   parameter logic [31:0] H_INIT3 = 32'h9293E9E2,
   parameter logic [31:0] H_INIT4 = 32'hCDEF23A9,
   parameter int unsigned UNROLL  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [31:0]  msg_data,
   input  logic         msg_last,
   output logic         busy,
   output logic         done,
   output logic [159:0] digest
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      UPDATE,
      DONE
   } state_t;

   generate
      if (!(UNROLL == 1 || UNROLL == 2 ||
            UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
         $error("sha1_stream_core: UNROLL must be 1, 2, 4 or 5");
      end
   endgenerate

   localparam logic [6:0] RSTEP = 7'(UNROLL);
   localparam logic [6:0] RLAST = 7'(80 - UNROLL);

   state_t      state;
   logic [31:0] h0, h1, h2, h3, h4;
   logic [31:0] a, b, c, d, e;
   logic [31:0] w [16];
   logic [3:0]  wcnt;
   logic [6:0]  rcnt;
   logic        last_q;

   logic [31:0] an, bn, cn, dn, en;
   logic [31:0] wn [16];
   logic [31:0] tmp, nw;
   logic [6:0]  t;
   logic [31:0] s0, s1, s2, s3, s4;

   function automatic logic [31:0] f_fn(
      input logic [6:0]  ti,
      input logic [31:0] x,
      input logic [31:0] y,
      input logic [31:0] z
   );
      if (ti < 7'd20)      return (x & y) | (~x & z);
      else if (ti < 7'd40) return x ^ y ^ z;
      else if (ti < 7'd60) return (x & y) | (x & z) | (y & z);
      else                 return x ^ y ^ z;
   endfunction

   function automatic logic [31:0] k_fn(input logic [6:0] ti);
      if (ti < 7'd20)      return 32'h5A827999;
      else if (ti < 7'd40) return 32'h6ED9EBA1;
      else if (ti < 7'd60) return 32'h8F1BBCDC;
      else                 return 32'hCA62C1D6;
   endfunction

   // w[0] always holds W[t]; each round shifts the window down by one
   // and appends W[t+16] = rotl1(W[t+13]^W[t+8]^W[t+2]^W[t]).
   always_comb begin
      wn  = w;
      an  = a;
      bn  = b;
      cn  = c;
      dn  = d;
      en  = e;
      tmp = '0;
      nw  = '0;
      t   = rcnt;
      for (int k = 0; k < int'(UNROLL); k++) begin
         t   = rcnt + 7'(k);
         tmp = {an[26:0], an[31:27]} + f_fn(t, bn, cn, dn)
               + en + k_fn(t) + wn[0];
         nw  = wn[13] ^ wn[8] ^ wn[2] ^ wn[0];
         nw  = {nw[30:0], nw[31]};
         en  = dn;
         dn  = cn;
         cn  = {bn[1:0], bn[31:2]};
         bn  = an;
         an  = tmp;
         for (int j = 0; j < 15; j++) wn[j] = wn[j+1];
         wn[15] = nw;
      end
   end

   assign s0 = h0 + a;
   assign s1 = h1 + b;
   assign s2 = h2 + c;
   assign s3 = h3 + d;
   assign s4 = h4 + e;

   assign msg_ready = (state == LOAD);
   assign busy      = (state == LOAD) || (state == ROUND) ||
                      (state == UPDATE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         h0     <= H_INIT0;
         h1     <= H_INIT1;
         h2     <= H_INIT2;
         h3     <= H_INIT3;
         h4     <= H_INIT4;
         a      <= H_INIT0;
         b      <= H_INIT1;
         c      <= H_INIT2;
         d      <= H_INIT3;
         e      <= H_INIT4;
         wcnt   <= '0;
         rcnt   <= '0;
         last_q <= 1'b0;
         done   <= 1'b0;
         digest <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  h0    <= H_INIT0;
                  h1    <= H_INIT1;
                  h2    <= H_INIT2;
                  h3    <= H_INIT3;
                  h4    <= H_INIT4;
                  wcnt  <= '0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (msg_valid) begin
                  for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                  w[15] <= msg_data;
                  wcnt  <= wcnt + 4'd1;
                  if (wcnt == 4'd15) begin
                     last_q <= msg_last;
                     a      <= h0;
                     b      <= h1;
                     c      <= h2;
                     d      <= h3;
                     e      <= h4;
                     rcnt   <= '0;
                     state  <= ROUND;
                  end
               end
            end
            ROUND: begin
               w    <= wn;
               a    <= an;
               b    <= bn;
               c    <= cn;
               d    <= dn;
               e    <= en;
               rcnt <= rcnt + RSTEP;
               if (rcnt == RLAST) state <= UPDATE;
            end
            UPDATE: begin
               h0 <= s0;
               h1 <= s1;
               h2 <= s2;
               h3 <= s3;
               h4 <= s4;
               if (last_q) begin
                  digest <= {s0, s1, s2, s3, s4};
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  wcnt  <= '0;
                  state <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_stream_core.sv
// tb_sha1_stream_core: scoreboard bench over UNROLL 1/2/4/5 and default-IV cores.
// Drives padded messages with optional valid gaps; checks digest, latency, flags.
module tb_sha1_stream_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [4:0]   start_v;
   logic         msg_valid;
   logic [31:0]  msg_data;
   logic         msg_last;
   logic [4:0]   rdy_v;
   logic [4:0]   busy_v;
   logic [4:0]   done_v;
   logic [159:0] dig_v [5];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [159:0] dig;
      int           lat;
   } exp_t;
   exp_t sb[$];

   logic [159:0] last_dig [5];
   logic [31:0]  abc_w [16];
   logic [31:0]  two_w [32];

   localparam int UL [4] = '{1, 2, 4, 5};
   localparam int UNR [5] = '{1, 2, 4, 5, 1};

   localparam logic [159:0] ABC_DIG =
      160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] TWO_DIG =
      160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
   localparam logic [159:0] DEF_IV =
      {32'h67DE2A01, 32'hBB03E28C, 32'h011EF1DC,
       32'h9293E9E2, 32'hCDEF23A9};

   for (genvar g = 0; g < 4; g++) begin : g_std
      sha1_stream_core #(
         .H_INIT0(32'h67452301),
         .H_INIT1(32'hEFCDAB89),
         .H_INIT2(32'h98BADCFE),
         .H_INIT3(32'h10325476),
         .H_INIT4(32'hC3D2E1F0),
         .UNROLL (UL[g])
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .start    (start_v[g]),
         .msg_valid(msg_valid),
         .msg_ready(rdy_v[g]),
         .msg_data (msg_data),
         .msg_last (msg_last),
         .busy     (busy_v[g]),
         .done     (done_v[g]),
         .digest   (dig_v[g])
      );
   end

   sha1_stream_core u_def (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[4]),
      .msg_valid(msg_valid),
      .msg_ready(rdy_v[4]),
      .msg_data (msg_data),
      .msg_last (msg_last),
      .busy     (busy_v[4]),
      .done     (done_v[4]),
      .digest   (dig_v[4])
   );

   // Straightforward FIPS 180 compression over a full 80-word schedule.
   function automatic logic [159:0] sha1_ref(
      input logic [159:0] hin,
      input logic [31:0]  m [16]
   );
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, tmp, x;
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 80; t++) begin
         x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
         w[t] = {x[30:0], x[31]};
      end
      a = hin[159:128];
      b = hin[127:96];
      c = hin[95:64];
      d = hin[63:32];
      e = hin[31:0];
      for (int t = 0; t < 80; t++) begin
         if (t < 20) begin
            f = (b & c) | (~b & d);
            k = 32'h5A827999;
         end else if (t < 40) begin
            f = b ^ c ^ d;
            k = 32'h6ED9EBA1;
         end else if (t < 60) begin
            f = (b & c) | (b & d) | (c & d);
            k = 32'h8F1BBCDC;
         end else begin
            f = b ^ c ^ d;
            k = 32'hCA62C1D6;
         end
         tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
         e   = d;
         d   = c;
         c   = {b[1:0], b[31:2]};
         b   = a;
         a   = tmp;
      end
      return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c,
              hin[63:32] + d, hin[31:0] + e};
   endfunction

   // poke: 0 none, 1 start pulse mid-ROUND, 2 reset mid-ROUND (aborts).
   task automatic run_msg(
      input int           dn,
      input int           kind,
      input bit           gaps,
      input int           poke,
      input logic [159:0] exp_dig
   );
      exp_t ex;
      int   nblk, waited, t_acc, lat;
      bit   early;
      ex.dig = exp_dig;
      ex.lat = 80 / UNR[dn] + 2;
      sb.push_back(ex);
      nblk  = (kind == 1) ? 2 : 1;
      early = 1'b0;
      @(negedge clk);
      // junk word alongside start must not be taken
      start_v[dn] = 1'b1;
      msg_valid   = 1'b1;
      msg_data    = 32'hDEADBEEF;
      msg_last    = 1'b1;
      @(negedge clk);
      start_v[dn] = 1'b0;
      for (int bk = 0; bk < nblk; bk++) begin
         for (int i = 0; i < 16; i++) begin
            if (gaps) begin
               msg_valid = 1'b0;
               repeat ($urandom_range(0, 3)) begin
                  @(negedge clk);
                  if (done_v[dn]) early = 1'b1;
               end
            end
            msg_valid = 1'b1;
            msg_data  = (kind == 1) ? two_w[bk*16+i] : abc_w[i];
            msg_last  = (bk == nblk - 1);
            waited    = 0;
            while (!rdy_v[dn] && waited < 300) begin
               @(negedge clk);
               if (done_v[dn]) early = 1'b1;
               waited++;
            end
            if (waited >= 300) begin
               errors++;
               checks++;
               $display("FAIL load_timeout dut=%0d ready=%b want 1",
                        dn, rdy_v[dn]);
               void'(sb.pop_back());
               msg_valid = 1'b0;
               return;
            end
            @(negedge clk);
            if (done_v[dn]) early = 1'b1;
         end
      end
      t_acc     = cyc;
      msg_valid = 1'b0;
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL early_done dut=%0d got %b want 0", dn, early);
      end
      if (poke != 0) begin
         repeat (5) @(negedge clk);
         checks++;
         if (busy_v[dn] !== 1'b1) begin
            errors++;
            $display("FAIL busy_round dut=%0d got %b want 1",
                     dn, busy_v[dn]);
         end
         checks++;
         if (rdy_v[dn] !== 1'b0) begin
            errors++;
            $display("FAIL ready_round dut=%0d got %b want 0",
                     dn, rdy_v[dn]);
         end
         if (poke == 1) begin
            start_v[dn] = 1'b1;
            @(negedge clk);
            start_v[dn] = 1'b0;
            checks++;
            if (busy_v[dn] !== 1'b1) begin
               errors++;
               $display("FAIL start_ignored dut=%0d busy %b want 1",
                        dn, busy_v[dn]);
            end
            checks++;
            if (dig_v[dn] !== last_dig[dn]) begin
               errors++;
               $display("FAIL digest_hold_round dut=%0d got %h want %h",
                        dn, dig_v[dn], last_dig[dn]);
            end
         end else begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (busy_v[dn] !== 1'b0 || rdy_v[dn] !== 1'b0 ||
                done_v[dn] !== 1'b0) begin
               errors++;
               $display("FAIL reset_flags dut=%0d busy/rdy/done %b%b%b want 000",
                        dn, busy_v[dn], rdy_v[dn], done_v[dn]);
            end
            checks++;
            if (dig_v[dn] !== 160'd0) begin
               errors++;
               $display("FAIL reset_digest dut=%0d got %h want 0",
                        dn, dig_v[dn]);
            end
            @(negedge clk);
            rst_n = 1'b1;
            void'(sb.pop_back());
            repeat (3) @(negedge clk);
            checks++;
            if (busy_v[dn] !== 1'b0 || rdy_v[dn] !== 1'b0) begin
               errors++;
               $display("FAIL idle_after_reset dut=%0d busy/rdy %b%b want 00",
                        dn, busy_v[dn], rdy_v[dn]);
            end
            return;
         end
      end
      waited = 0;
      while (!done_v[dn] && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 300) begin
         errors++;
         checks++;
         $display("FAIL done_timeout dut=%0d done=%b want 1",
                  dn, done_v[dn]);
         void'(sb.pop_front());
         return;
      end
      // edges counted inclusively: accepting edge through done-raising edge
      lat = cyc - t_acc + 1;
      ex  = sb.pop_front();
      checks++;
      if (dig_v[dn] !== ex.dig) begin
         errors++;
         $display("FAIL digest dut=%0d got %h want %h", dn, dig_v[dn], ex.dig);
      end
      checks++;
      if (lat !== ex.lat) begin
         errors++;
         $display("FAIL latency dut=%0d got %0d want %0d", dn, lat, ex.lat);
      end
      checks++;
      if (busy_v[dn] !== 1'b0 || rdy_v[dn] !== 1'b0) begin
         errors++;
         $display("FAIL done_flags dut=%0d busy/rdy %b%b want 00",
                  dn, busy_v[dn], rdy_v[dn]);
      end
      last_dig[dn] = ex.dig;
      @(negedge clk);
      checks++;
      if (done_v[dn] !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse dut=%0d got %b want 0", dn, done_v[dn]);
      end
      checks++;
      if (dig_v[dn] !== ex.dig) begin
         errors++;
         $display("FAIL digest_hold dut=%0d got %h want %h",
                  dn, dig_v[dn], ex.dig);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start_v   = '0;
      msg_valid = 1'b0;
      msg_data  = '0;
      msg_last  = 1'b0;
      repeat (3) @(negedge clk);
      for (int dn = 0; dn < 5; dn++) begin
         checks++;
         if (rdy_v[dn] !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready dut=%0d got %b want 0", dn, rdy_v[dn]);
         end
         checks++;
         if (busy_v[dn] !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy dut=%0d got %b want 0", dn, busy_v[dn]);
         end
         checks++;
         if (done_v[dn] !== 1'b0) begin
            errors++;
            $display("FAIL rst_done dut=%0d got %b want 0", dn, done_v[dn]);
         end
         checks++;
         if (dig_v[dn] !== 160'd0) begin
            errors++;
            $display("FAIL rst_digest dut=%0d got %h want 0", dn, dig_v[dn]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abc();
      for (int dn = 0; dn < 4; dn++) run_msg(dn, 0, 1'b0, 0, ABC_DIG);
      for (int dn = 1; dn < 4; dn++) run_msg(dn, 0, 1'b1, 0, ABC_DIG);
   endtask

   task automatic test_two_block();
      for (int dn = 0; dn < 4; dn++) run_msg(dn, 1, 1'b1, 0, TWO_DIG);
   endtask

   task automatic test_start_in_round();
      run_msg(0, 0, 1'b1, 1, ABC_DIG);
   endtask

   task automatic test_reset_mid_round();
      run_msg(1, 0, 1'b0, 2, ABC_DIG);
      run_msg(1, 0, 1'b1, 0, ABC_DIG);
   endtask

   task automatic test_back_to_back();
      logic [159:0] ref_dig;
      ref_dig = sha1_ref(DEF_IV, abc_w);
      run_msg(4, 0, 1'b0, 0, ref_dig);
      run_msg(4, 0, 1'b1, 1, ref_dig);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) abc_w[i] = '0;
      abc_w[0]  = 32'h61626380;
      abc_w[15] = 32'h00000018;
      two_w[0]  = 32'h61626364;
      two_w[1]  = 32'h62636465;
      two_w[2]  = 32'h63646566;
      two_w[3]  = 32'h64656667;
      two_w[4]  = 32'h65666768;
      two_w[5]  = 32'h66676869;
      two_w[6]  = 32'h6768696a;
      two_w[7]  = 32'h68696a6b;
      two_w[8]  = 32'h696a6b6c;
      two_w[9]  = 32'h6a6b6c6d;
      two_w[10] = 32'h6b6c6d6e;
      two_w[11] = 32'h6c6d6e6f;
      two_w[12] = 32'h6d6e6f70;
      two_w[13] = 32'h6e6f7071;
      two_w[14] = 32'h80000000;
      for (int i = 15; i < 32; i++) two_w[i] = '0;
      two_w[31] = 32'h000001c0;
      for (int i = 0; i < 5; i++) last_dig[i] = '0;

      test_reset();
      test_abc();
      test_two_block();
      test_start_in_round();
      test_reset_mid_round();
      test_back_to_back();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sha1_stream_core.md
SHA1_STREAM_CORE -- requirements
Module: sha1_stream_core

Interface
REQ-001 Parameter H_INIT0, default 32'h67DE2A01, initial hash word 0.
REQ-002 Parameter H_INIT1, default 32'hBB03E28C, initial hash word 1.
REQ-003 Parameter H_INIT2, default 32'h011EF1DC, initial hash word 2.
REQ-004 Parameter H_INIT3, default 32'h9293E9E2, initial hash word 3.
REQ-005 Parameter H_INIT4, default 32'hCDEF23A9, initial hash word 4.
REQ-006 Parameter UNROLL, default 1, is the number of rounds per clock; the only legal values SHALL be 1, 2, 4 and 5, and any other value SHALL be an elaboration error.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset; asynchronous and active-low.
REQ-009 start  in  1  begin a new message: reload H from H_INIT*.
REQ-010 msg_valid  in  1  msg_data holds a valid message word.
REQ-011 msg_ready  out  1  core accepts a word this cycle.
REQ-012 msg_data  in  32  pre-padded message word, big-endian word order W0 first.
REQ-013 msg_last  in  1  sampled with the 16th word of a block; 1 = final block of the message.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  one-cycle pulse when digest becomes valid.
REQ-016 digest  out  160  final hash, {H0,H1,H2,H3,H4}, H0 in bits 159:128.

Function
REQ-017 States SHALL be IDLE, LOAD, ROUND, UPDATE and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load H0..H4 from H_INIT*, clear the word counter and move to LOAD.
REQ-019 start SHALL be ignored in LOAD, ROUND and UPDATE.
REQ-020 msg_ready SHALL be 1 only in LOAD.
REQ-021 A word SHALL be accepted only on a cycle with msg_valid and msg_ready both high; gaps in msg_valid SHALL stall LOAD indefinitely without loss.
REQ-022 Accepted words SHALL fill a 16x32 schedule window; the 16th accept SHALL latch msg_last, copy H0..H4 into A..E and move to ROUND.
REQ-023 ROUND SHALL last exactly 80/UNROLL cycles, and each cycle SHALL perform UNROLL consecutive rounds t.
REQ-024 Each round SHALL compute temp = rotl5(A) + f(t) + E + K(t) + W[t] mod 2^32, then E<=D, D<=C, C<=rotl30(B), B<=A, A<=temp.
REQ-025 For t 0-19, f SHALL be (B&C)|(~B&D) and K SHALL be 5A827999.
REQ-026 For t 20-39, f SHALL be B^C^D and K SHALL be 6ED9EBA1.
REQ-027 For t 40-59, f SHALL be (B&C)|(B&D)|(C&D) and K SHALL be 8F1BBCDC.
REQ-028 For t 60-79, f SHALL be B^C^D and K SHALL be CA62C1D6.
REQ-029 For t<16, W[t] SHALL be the loaded word; for t>=16, W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), produced in the rolling window with no external RAM.
REQ-030 UPDATE SHALL last one cycle and SHALL set Hi <= Hi + {A..E}i mod 2^32.
REQ-031 From UPDATE, latched msg_last=0 SHALL go to LOAD for the next block with H chained (multi-block message).
REQ-032 From UPDATE, latched msg_last=1 SHALL go to DONE, register digest and assert done for exactly that first DONE cycle.
REQ-033 Latency SHALL be exactly 80/UNROLL+2 clock edges from the edge accepting the 16th word of the last block to the edge raising done.
REQ-034 digest SHALL hold its value until the next done or reset; start SHALL NOT clear it.
REQ-035 start asserted together with msg_valid in IDLE SHALL NOT accept that word; words are accepted from the next cycle.

Reset
REQ-036 While rst_n=0, the core SHALL be in IDLE with msg_ready=0, busy=0, done=0, digest=0, H0..H4=H_INIT*, A..E=H_INIT*, word counter=0 and round counter=0.
REQ-037 Reset asserted in any state SHALL abort the message immediately; a partial block SHALL be discarded.
REQ-038 After rst_n deasserts, the core SHALL wait in IDLE for start.

Verification
REQ-039 With H_INIT* overridden to the standard SHA-1 IV (67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0) and UNROLL=1, the padded "abc" single block with msg_last=1 SHALL produce done after 82 edges and digest=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
REQ-040 With the standard IV, the 2-block "abcdbcdecdef...nopq" (448-bit) message SHALL produce digest=84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1, with no done after block 1.
REQ-041 The REQ-039 and REQ-040 stimuli repeated with UNROLL=2, 4 and 5 and random msg_valid gaps SHALL produce identical digests, with done latency 42, 22 and 18 edges respectively.
REQ-042 A start pulse during ROUND SHALL be ignored and the digest unchanged; rst_n pulsed low mid-ROUND SHALL give IDLE, busy=0 and digest=0, and a following fresh "abc" SHALL hash correctly.
REQ-043 With the default parameters, two back-to-back "abc" messages (start issued in DONE) SHALL yield identical digests, confirming H is reloaded and not chained across messages.
